// File: rtl/rr_output_scheduler_pkg.sv
// Shared types and width helpers for the round-robin output scheduler.
package rr_output_scheduler_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_W_DEF     = 32;
  localparam int CREDIT_MAX_DEF = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cred_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_output_scheduler_if.sv
// Requester/link/credit bundle between the input buffers, the scheduler and the link.
interface rr_output_scheduler_if
  import rr_output_scheduler_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ-1:0]        in_tail;
  logic [NUM_REQ*DATA_W-1:0] in_data;
  logic [NUM_REQ-1:0]        in_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_tail;
  logic                      credit_ret;
  logic [NUM_REQ-1:0]        grant;
  logic                      credit_err;

  modport master (
    output in_valid, in_tail, in_data, credit_ret,
    input  in_ready, out_valid, out_data, out_tail, grant, credit_err
  );

  modport slave (
    input  in_valid, in_tail, in_data, credit_ret,
    output in_ready, out_valid, out_data, out_tail, grant, credit_err
  );
endinterface

// File: rtl/rr_output_scheduler_pick.sv
// Combinational rotating-priority picker: first unmasked request at or after ptr.
module rr_pick
  import rr_output_scheduler_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j] && !mask[j]) begin
        any       = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_output_scheduler.sv
// Round-robin output scheduler with wormhole lock and credit gating.
// Build option: RR_FAST_REARB_EN re-arbitrates on a tail flit without an idle bubble.
module rr_output_scheduler
  import rr_output_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF
) (
  input logic                  clk,
  input logic                  rst,
  rr_output_scheduler_if.slave bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = cred_w(CREDIT_MAX);
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_r, grant_n;
  logic [IW-1:0]      w, w_n;
  logic [IW-1:0]      ptr, ptr_n;
  logic [CW-1:0]      credits, credits_n;
  logic               cerr, cerr_n;
  logic               xfer;
  logic [IW-1:0]      w_inc;

  logic [NUM_REQ-1:0] p_oh;
  logic [IW-1:0]      p_idx;
  logic               p_any;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (bus.in_valid),
    .ptr    (ptr),
    .mask   ('0),
    .onehot (p_oh),
    .idx    (p_idx),
    .any    (p_any)
  );

  assign w_inc = (int'(w) == NUM_REQ - 1) ? '0 : w + IW'(1);

`ifdef RR_FAST_REARB_EN
  logic [NUM_REQ-1:0] f_oh;
  logic [IW-1:0]      f_idx;
  logic               f_any;

  // Current owner is masked so it cannot win twice in a row while others wait.
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_fast (
    .req    (bus.in_valid),
    .ptr    (w_inc),
    .mask   (grant_r),
    .onehot (f_oh),
    .idx    (f_idx),
    .any    (f_any)
  );
`endif

  assign xfer           = (state == LOCKED) && bus.in_valid[w] && (credits != '0);
  assign bus.out_valid  = xfer;
  assign bus.out_data   = bus.in_data[w*DATA_W +: DATA_W];
  assign bus.out_tail   = bus.in_tail[w];
  assign bus.in_ready   = grant_r & {NUM_REQ{xfer}};
  assign bus.grant      = grant_r;
  assign bus.credit_err = cerr;

  always_comb begin
    state_n = state;
    grant_n = grant_r;
    w_n     = w;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (p_any) begin
          grant_n = p_oh;
          w_n     = p_idx;
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        // Grant only moves on a transferred tail; stalls keep the packet locked.
        if (xfer && bus.in_tail[w]) begin
          ptr_n = w_inc;
`ifdef RR_FAST_REARB_EN
          if (f_any) begin
            grant_n = f_oh;
            w_n     = f_idx;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
`else
          grant_n = '0;
          state_n = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    credits_n = credits;
    cerr_n    = cerr;
    if (bus.credit_ret && credits == CMAX) cerr_n = 1'b1;
    if (xfer && !bus.credit_ret)
      credits_n = credits - CW'(1);
    else if (!xfer && bus.credit_ret && credits != CMAX)
      credits_n = credits + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_r <= '0;
      w       <= '0;
      ptr     <= '0;
      credits <= CMAX;
      cerr    <= 1'b0;
    end else begin
      state   <= state_n;
      grant_r <= grant_n;
      w       <= w_n;
      ptr     <= ptr_n;
      credits <= credits_n;
      cerr    <= cerr_n;
    end
  end

endmodule

// File: tb/tb_rr_output_scheduler.sv
// Directed bench for rr_output_scheduler (NUM_REQ=4, DATA_W=32, CREDIT_MAX=4).
module tb_rr_output_scheduler;

  localparam logic [31:0] D0 = 32'hA000_0000;
  localparam logic [31:0] D1 = 32'hB111_1111;
  localparam logic [31:0] D2 = 32'hC222_2222;
  localparam logic [31:0] D3 = 32'hD333_3333;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  rr_output_scheduler_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

  rr_output_scheduler #(.NUM_REQ(4), .DATA_W(32), .CREDIT_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.in_valid   = '0;
    bus.in_tail    = '0;
    bus.credit_ret = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic idle_then_step(input string tag);
    chk({tag, "_idle_grant"}, 32'(bus.grant), 32'h0);
    chk({tag, "_idle_ov"}, 32'(bus.out_valid), 32'h0);
    step();
  endtask

  initial begin
    logic [3:0] expg;
    n_chk       = 0;
    n_err       = 0;
    bus.in_data = {D3, D2, D1, D0};

    // 1: alternating single-flit packets from requesters 0 and 2
    do_reset();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_ov", 32'(bus.out_valid), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_credits", 32'(dut.credits), 32'd4);
    chk("rst_err", 32'(bus.credit_err), 32'h0);
    chk("rst_ptr", 32'(dut.ptr), 32'h0);
    bus.in_valid = 4'b0101;
    bus.in_tail  = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      expg = (p % 2 == 0) ? 4'b0001 : 4'b0100;
`ifdef RR_FAST_REARB_EN
      if (p == 0) idle_then_step("t1");
`else
      idle_then_step("t1");
`endif
      bus.credit_ret = 1'b1;
      #1;
      chk("t1_grant", 32'(bus.grant), 32'(expg));
      chk("t1_ov", 32'(bus.out_valid), 32'h1);
      chk("t1_ready", 32'(bus.in_ready), 32'(expg));
      chk("t1_data", bus.out_data, (p % 2 == 0) ? D0 : D2);
      step();
      bus.credit_ret = 1'b0;
    end
    chk("t1_credits", 32'(dut.credits), 32'd4);

    // 2: 3-flit wormhole packet from req0 while req1 waits
    do_reset();
    bus.in_valid = 4'b0011;
    bus.in_tail  = 4'b0000;
    step();
    for (int f = 0; f < 3; f++) begin
      bus.in_tail = (f == 2) ? 4'b0001 : 4'b0000;
      #1;
      chk("t2_grant", 32'(bus.grant), 32'h1);
      chk("t2_ov", 32'(bus.out_valid), 32'h1);
      chk("t2_data", bus.out_data, D0);
      chk("t2_tail", 32'(bus.out_tail), (f == 2) ? 32'h1 : 32'h0);
      chk("t2_ready", 32'(bus.in_ready), 32'h1);
      step();
    end
    bus.in_tail = 4'b0000;
`ifndef RR_FAST_REARB_EN
    #1;
    chk("t2_bubble", 32'(bus.grant), 32'h0);
    step();
`endif
    #1;
    chk("t2_next_grant", 32'(bus.grant), 32'h2);
    chk("t2_next_data", bus.out_data, D1);
    chk("t2_credits", 32'(dut.credits), 32'd1);

    // 3/4: credit exhaustion, hold, single credit return
    do_reset();
    bus.in_valid = 4'b0001;
    bus.in_tail  = 4'b0000;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t3_xfer", 32'(bus.out_valid), 32'h1);
      step();
    end
    chk("t3_stall_ov", 32'(bus.out_valid), 32'h0);
    chk("t3_stall_grant", 32'(bus.grant), 32'h1);
    chk("t3_stall_ready", 32'(bus.in_ready), 32'h0);
    chk("t3_credits0", 32'(dut.credits), 32'd0);
    step();
    chk("t3_hold_ov", 32'(bus.out_valid), 32'h0);
    bus.credit_ret = 1'b1;
    #1;
    chk("t4_ret_ov", 32'(bus.out_valid), 32'h0);
    step();
    bus.credit_ret = 1'b0;
    #1;
    chk("t4_credits1", 32'(dut.credits), 32'd1);
    chk("t4_xfer", 32'(bus.out_valid), 32'h1);
    chk("t4_ready", 32'(bus.in_ready), 32'h1);
    step();
    chk("t4_credits_back0", 32'(dut.credits), 32'd0);
    chk("t4_ov_after", 32'(bus.out_valid), 32'h0);

    // 5: credit overflow is sticky until reset
    do_reset();
    bus.credit_ret = 1'b1;
    step();
    bus.credit_ret = 1'b0;
    #1;
    chk("t5_credits", 32'(dut.credits), 32'd4);
    chk("t5_err", 32'(bus.credit_err), 32'h1);
    step();
    step();
    chk("t5_err_sticky", 32'(bus.credit_err), 32'h1);
    do_reset();
    chk("t5_err_clr", 32'(bus.credit_err), 32'h0);

    // 6: reset mid-packet
    bus.in_valid = 4'b0100;
    step();
    chk("t6_grant", 32'(bus.grant), 32'h4);
    chk("t6_ov", 32'(bus.out_valid), 32'h1);
    step();
    chk("t6_credits", 32'(dut.credits), 32'd3);
    rst = 1'b1;
    step();
    chk("t6_rst_grant", 32'(bus.grant), 32'h0);
    chk("t6_rst_credits", 32'(dut.credits), 32'd4);
    chk("t6_rst_ptr", 32'(dut.ptr), 32'h0);
    chk("t6_rst_ov", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
